serial_cla_sequencer: RTL and testbench

SERIAL_CLA_SEQUENCER -- requirements
Module: serial_cla_sequencer

---
 rtl/serial_cla_sequencer.sv | 135 +++++++++++++
 tb/tb_serial_cla_sequencer.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/serial_cla_sequencer.sv
// Serial adder: one 4-bit carry-lookahead slice per cycle, with a valid/ready
// handshake on both sides and abort support.
module serial_cla_sequencer #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             abort,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf,
    output logic             prop_all,
    output logic             busy
);

    localparam int unsigned NSLICE = WIDTH / 4;
    localparam int unsigned KW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [KW-1:0] KLast = KW'(NSLICE - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q, state_d;
    logic [KW-1:0]    k_q, k_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cr_q, cr_d;
    logic             pr_q, pr_d;
    logic             c_out_q, c_out_d;
    logic             ovf_q, ovf_d;

    logic [3:0] a_sl, b_sl, g, p, c, s;

    // Lookahead for the current slice, carries flattened in generate/propagate form
    always_comb begin
        a_sl = a_q[{k_q, 2'b00} +: 4];
        b_sl = b_q[{k_q, 2'b00} +: 4];
        g    = a_sl & b_sl;
        p    = a_sl ^ b_sl;
        c[0] = g[0] | (p[0] & cr_q);
        c[1] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cr_q);
        c[2] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cr_q);
        c[3] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & cr_q);
        s    = p ^ {c[2:0], cr_q};
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cr_d    = cr_q;
        pr_d    = pr_q;
        c_out_d = c_out_q;
        ovf_d   = ovf_q;

        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    k_d     = '0;
                    cr_d    = c_in;
                    pr_d    = 1'b1;
                    state_d = StRun;
                end
            end
            StRun: begin
                if (abort) begin
                    state_d = StIdle;
                end else begin
                    sum_d[{k_q, 2'b00} +: 4] = s;
                    cr_d = c[3];
                    pr_d = pr_q & (&p);
                    if (k_q == KLast) begin
                        k_d     = '0;
                        c_out_d = c[3];
                        ovf_d   = c[3] ^ c[2];
                        state_d = StDone;
                    end else begin
                        k_d = k_q + 1'b1;
                    end
                end
            end
            StDone: begin
                if (abort || out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            k_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cr_q    <= 1'b0;
            pr_q    <= 1'b0;
            c_out_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cr_q    <= cr_d;
            pr_q    <= pr_d;
            c_out_q <= c_out_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign busy      = (state_q != StIdle);
    assign sum       = sum_q;
    assign c_out     = c_out_q;
    assign ovf       = ovf_q;
    assign prop_all  = pr_q;

endmodule

// File: tb/tb_serial_cla_sequencer.sv
// Directed bench for serial_cla_sequencer (WIDTH=32) with a small arithmetic
// reference model and a short randomised tail.
module tb_serial_cla_sequencer;

    localparam int W  = 32;
    localparam int NS = W / 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          c_in;
    logic          abort;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  sum;
    logic          c_out;
    logic          ovf;
    logic          prop_all;
    logic          busy;

    int total = 0;
    int bad   = 0;

    serial_cla_sequencer #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .c_in     (c_in),
        .abort    (abort),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum      (sum),
        .c_out    (c_out),
        .ovf      (ovf),
        .prop_all (prop_all),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Full operation; the expected result comes from plain integer arithmetic.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb,
                          input logic tc, input int hold, input string tag);
        logic [W:0]   full;
        logic         e_ovf;
        logic         e_prop;
        logic [W-1:0] held;
        int           n;
        full   = {1'b0, ta} + {1'b0, tb} + {{W{1'b0}}, tc};
        e_ovf  = (ta[W-1] == tb[W-1]) && (full[W-1] != ta[W-1]);
        e_prop = &(ta ^ tb);
        chk({tag, ".in_ready"}, 64'(in_ready), 64'd1);
        a = ta; b = tb; c_in = tc; in_valid = 1'b1; out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        a = $urandom; b = $urandom; c_in = ~tc;
        n = 0;
        while (!out_valid && n < 20) begin
            step();
            n++;
        end
        chk({tag, ".latency"}, 64'(n), 64'(NS));
        chk({tag, ".sum"}, 64'(sum), 64'(full[W-1:0]));
        chk({tag, ".c_out"}, 64'(c_out), 64'(full[W]));
        chk({tag, ".ovf"}, 64'(ovf), 64'(e_ovf));
        chk({tag, ".prop"}, 64'(prop_all), 64'(e_prop));
        held = full[W-1:0];
        for (int i = 0; i < hold; i++) begin
            in_valid = ~in_valid;
            a = $urandom; b = $urandom;
            step();
            chk({tag, ".hold_valid"}, 64'(out_valid), 64'd1);
            chk({tag, ".hold_sum"}, 64'(sum), 64'(held));
            chk({tag, ".hold_rdy"}, 64'(in_ready), 64'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk({tag, ".release_valid"}, 64'(out_valid), 64'd0);
        chk({tag, ".release_rdy"}, 64'(in_ready), 64'd1);
    endtask

    // Accept an operation, interrupt it after kk RUN edges with abort or reset.
    task automatic cut_op(input int kk, input logic use_rst, input string tag);
        a = $urandom; b = $urandom; c_in = 1'b0; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < kk; i++) begin
            chk({tag, ".no_valid"}, 64'(out_valid), 64'd0);
            step();
        end
        if (use_rst) rst = 1'b1; else abort = 1'b1;
        out_ready = 1'b1;
        step();
        rst = 1'b0; abort = 1'b0; out_ready = 1'b0;
        chk({tag, ".idle_valid"}, 64'(out_valid), 64'd0);
        chk({tag, ".idle_busy"}, 64'(busy), 64'd0);
        chk({tag, ".idle_rdy"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b1; a = '1; b = '1; c_in = 1'b1; abort = 1'b1;
        out_ready = 1'b1;
        step();
        step();
        rst = 1'b0; in_valid = 1'b0; abort = 1'b0; out_ready = 1'b0;
        chk("rst.in_ready", 64'(in_ready), 64'd1);
        chk("rst.busy", 64'(busy), 64'd0);
        chk("rst.out_valid", 64'(out_valid), 64'd0);
        chk("rst.sum", 64'(sum), 64'd0);
        chk("rst.flags", 64'({c_out, ovf, prop_all}), 64'd0);

        run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 0, "v_wrap");
        chk("v_wrap.const", 64'({sum, c_out, ovf, prop_all}), 64'({32'h0, 3'b100}));
        run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 0, "v_ovf");
        run_op(32'hAAAA_AAAA, 32'h5555_5555, 1'b1, 5, "v_prop");

        cut_op(3, 1'b0, "abort_k3");
        cut_op(5, 1'b1, "rst_k5");
        chk("rst_k5.sum", 64'(sum), 64'd0);
        run_op(32'd3, 32'd4, 1'b0, 0, "after_cut");

        // Abort in DONE takes priority over out_ready: no second valid cycle
        cut_op(NS, 1'b0, "abort_done");

        // Abort while idle must not block acceptance
        abort = 1'b1; in_valid = 1'b1; a = 32'd1; b = 32'd1; c_in = 1'b0;
        step();
        abort = 1'b0; in_valid = 1'b0;
        chk("idle_abort.busy", 64'(busy), 64'd1);
        for (int i = 0; i < NS; i++) step();
        chk("idle_abort.sum", 64'(sum), 64'd2);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        for (int i = 0; i < 300; i++) begin
            if (i % 10 == 7) begin
                cut_op($urandom_range(NS - 1, 0), 1'b0, "rnd_abort");
            end else begin
                run_op($urandom, $urandom, 1'($urandom_range(1, 0)),
                       $urandom_range(3, 0), "rnd");
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
